reg_file_sb: RTL
================

# reg_file_sb

Register file with write-back bypass and a per-register pending-write scoreboard for the pipelined MIPS core. It sits directly downstream of the destination-register mux. At issue it takes the selected 5-bit destination (rt or rd) and marks that register busy. At write-back it commits data and clears the busy state. It drives the decode-stage stall when a source operand still has a write in flight.

## Interface
- DATA_W, 32, register width
- NREGS, 32, register count; address width is fixed at 5
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction presented at decode this cycle
- issue_wr  in  1  instruction writes a register (RegWrite)
- issue_dst  in  5  destination register from the destination mux
- rs_used, rt_used  in  1 each  instruction reads rs / rt
- rs_addr, rt_addr  in  5 each  source register numbers
- rs_data, rt_data  out  DATA_W each  source operands (combinational)
- wb_valid  in  1  write-back this cycle
- wb_dst  in  5  write-back register number
- wb_data  in  DATA_W  write-back data
- stall  out  1  hold decode; combinational
- sb_err  out  1  sticky scoreboard error

## Operation
- Register 0:
  - always reads 0.
  - Writes to it are discarded.
  - It never becomes busy, so issue_dst=0 and wb_dst=0 do not touch the scoreboard.
- Write: on a rising edge with wb_valid=1 and wb_dst≠0, regs[wb_dst] ← wb_data.
- Read:
  - rs_data = 0 if rs_addr=0.
  - Otherwise rs_data = wb_data if wb_valid and wb_dst=rs_addr.
  - Otherwise rs_data = regs[rs_addr].
  - rt_data uses the same rules with rt_addr.
- Scoreboard:
  - Each register r≠0 has a 2-bit counter pend[r] holding the number of issued, not-yet-written-back writes.
  - accept = issue_valid & issue_wr & ~stall & (issue_dst≠0).
  - retire = wb_valid & (wb_dst≠0).
  - For each register, on the clock edge:
    - accept only: +1.
    - retire only: −1.
    - accept and retire to the same register in the same cycle: unchanged.
  - Increment at pend=3: counter stays 3 and sb_err←1.
  - Retire at pend=0: counter stays 0 and sb_err←1.
  - sb_err stays set until rst.
- Busy:
  - busy(r) = (pend[r]≠0) and not (pend[r]=1 and retire and wb_dst=r).
  - The final outstanding write arriving this cycle does not count as busy, because the bypass supplies its data.
- stall = issue_valid & ((rs_used & busy(rs_addr)) | (rt_used & busy(rt_addr))).
  - A stalled instruction does not update the scoreboard.
  - Upstream holds all issue inputs while stall=1.
- No WAW stall. The environment retires writes in issue order.

## Timing
- Reads and stall are combinational from the inputs and current state, with zero-cycle latency.
- Writes and counters update on the rising edge. Data written at edge N is visible from regs after edge N, and through the bypass during the cycle before edge N.
- An instruction reading register r is released in the same cycle that the last pending write to r is on wb_*.
- Reset on an edge with rst=1:
  - all regs←0, all pend←0, sb_err←0.
  - Any simultaneous wb or issue on that edge is ignored.
- After reset with wb_valid=0: rs_data=rt_data=0, stall=0, sb_err=0.
- Reset mid-operation discards all pending state. Subsequent write-backs of those in-flight writes set sb_err (retire at 0).

## Test plan
- Reset, then write-back 32'hDEADBEEF to r5. Next cycle rs_addr=5 → rs_data=32'hDEADBEEF. Write-back 32'h1 to r0, then rt_addr=0 → rt_data=0.
- Bypass:
  - r7 holds 32'h11 and wb writes 32'h22 to r7 this cycle → rs_data=32'h22 in the same cycle.
  - Next cycle (wb_valid=0) → 32'h22.
- Load-use:
  - Issue with dst=8 (accepted).
  - Next instruction has rs_used=1, rs_addr=8 → stall=1 held for 3 idle cycles.
  - wb to r8 with 32'h55 → stall=0 that cycle and rs_data=32'h55.
- Two outstanding:
  - Issue dst=9 twice (pend=2).
  - First wb to r9 → reader still stalled.
  - Second wb → stall drops.
  - pend[9] ends at 0.
- Same-cycle issue dst=10 and wb to r10 with pend=1 → pend stays 1. The next reader of r10 stalls until one more wb.
- Errors:
  - 4 accepted issues to r12 → sb_err=1, pend=3.
  - rst → sb_err=0.
  - Then wb to r12 with pend=0 → sb_err=1, register still written.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with write-back bypass and a per-register pending-write
// scoreboard; raises the decode stall while a source still has a write in flight.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [4:0]        issue_dst,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_valid,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [1:0]        pend_q [NREGS];
    logic [1:0]        pend_d [NREGS];
    logic              sb_err_q, sb_err_d;
    logic              accept, retire;
    logic              rs_busy, rt_busy;

    assign retire = wb_valid && (wb_dst != 5'd0);

    // The last outstanding write landing this cycle is covered by the bypass,
    // so it releases the reader in the same cycle.
    assign rs_busy = (pend_q[rs_addr] != 2'd0) &&
                     !(pend_q[rs_addr] == 2'd1 && retire && wb_dst == rs_addr);
    assign rt_busy = (pend_q[rt_addr] != 2'd0) &&
                     !(pend_q[rt_addr] == 2'd1 && retire && wb_dst == rt_addr);

    assign stall  = issue_valid && ((rs_used && rs_busy) || (rt_used && rt_busy));
    assign accept = issue_valid && issue_wr && !stall && (issue_dst != 5'd0);

    always_comb begin
        if (rs_addr == 5'd0)                    rs_data = '0;
        else if (wb_valid && wb_dst == rs_addr) rs_data = wb_data;
        else                                    rs_data = regs_q[rs_addr];
    end

    always_comb begin
        if (rt_addr == 5'd0)                    rt_data = '0;
        else if (wb_valid && wb_dst == rt_addr) rt_data = wb_data;
        else                                    rt_data = regs_q[rt_addr];
    end

    // Counters saturate at both ends; any overflow/underflow latches sb_err.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            if (accept && issue_dst == 5'(r) && !(retire && wb_dst == 5'(r))) begin
                if (pend_q[r] == 2'd3) sb_err_d = 1'b1;
                else                   pend_d[r] = pend_q[r] + 2'd1;
            end else if (retire && wb_dst == 5'(r) && !(accept && issue_dst == 5'(r))) begin
                if (pend_q[r] == 2'd0) sb_err_d = 1'b1;
                else                   pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= 2'd0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (retire) regs_q[wb_dst] <= wb_data;
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule
